// File: rtl/wave_snd_pkg.sv
// wave_snd_pkg: shared constants, state type and sample conversion helpers
// for the wave_sound I2S output stage.
//   SLOTS_PER_FRAME : BCLK periods per stereo frame
//   SAMPLE_W        : width of the serialised PCM word
//   snd_state_t     : output stage state (PREFILL, RUN)
//   u8_to_s16       : unsigned 8-bit (0x80 = zero) to signed 16-bit
//   apply_vol       : scale signed 16-bit sample by (vol+1)/16
package wave_snd_pkg;

  localparam int SLOTS_PER_FRAME = 32;
  localparam int SAMPLE_W        = 16;

  typedef enum logic {
    PREFILL,
    RUN
  } snd_state_t;

  function automatic logic [SAMPLE_W-1:0] u8_to_s16(input logic [7:0] u8);
    return {~u8[7], u8[6:0], 8'h00};
  endfunction

  // Gain is (vol+1)/16; the product fits in 21 bits so the 22-bit result is
  // exact, and bits [19:4] are the arithmetic shift by 4 truncated to 16 bits.
  function automatic logic [SAMPLE_W-1:0] apply_vol(input logic [SAMPLE_W-1:0] s16,
                                                    input logic [3:0] vol);
    logic [4:0]         gain;
    logic signed [21:0] a;
    logic signed [21:0] b;
    logic signed [21:0] p;
    gain = {1'b0, vol} + 5'd1;
    a    = 22'($signed(s16));
    b    = 22'($signed({1'b0, gain}));
    p    = a * b;
    return p[19:4];
  endfunction

endpackage

// File: rtl/wave_snd_i2s_fifo.sv
// snd_fifo: single-clock first-word-fall-through FIFO.
//   clk_sys, reset : clock, asynchronous active-high reset (empties FIFO)
//   push, wr_data  : write strobe and data; ignored when full unless a pop
//                    frees a slot in the same cycle
//   pop, rd_data   : read strobe; rd_data shows the head entry combinationally
//   full, empty    : occupancy status
//   level          : registered occupancy, 0..DEPTH
module snd_fifo #(
  parameter int   DEPTH = 16,
  parameter int   WIDTH = 8,
  localparam int  AW    = $clog2(DEPTH),
  localparam int  LW    = AW + 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (level == LW'(DEPTH));
    empty   = (level == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rd_data = mem[rd_ptr];
  end

  // Storage carries no reset; resetting the pointers discards the contents.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/wave_snd_i2s.sv
// wave_snd_i2s: buffers 8-bit wave samples, applies volume and serialises
// them as mono-duplicated stereo I2S (32 BCLK slots per frame).
//   clk_sys, reset  : system clock, asynchronous active-high reset
//   I_SND           : unsigned sample, 0x80 = zero level
//   I_SND_VALID     : one-cycle push strobe
//   I_VOL           : volume, gain (I_VOL+1)/16, sampled at pop time
//   I_CLR_FLAGS     : clears the sticky flags (a coincident set wins)
//   O_BCLK, O_LRCK  : I2S bit clock and word select (0 = left)
//   O_SDATA         : serial data, MSB first, one-BCLK delayed
//   O_LEVEL         : FIFO occupancy
//   O_UNDERRUN      : sticky, frame start found the FIFO empty
//   O_OVERFLOW      : sticky, a push was dropped on a full FIFO
module wave_snd_i2s
  import wave_snd_pkg::*;
#(
  parameter int  CLK_DIV    = 2,
  parameter int  FIFO_DEPTH = 16,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [7:0]    I_SND,
  input  logic          I_SND_VALID,
  input  logic [3:0]    I_VOL,
  input  logic          I_CLR_FLAGS,
  output logic          O_BCLK,
  output logic          O_LRCK,
  output logic          O_SDATA,
  output logic [LW-1:0] O_LEVEL,
  output logic          O_UNDERRUN,
  output logic          O_OVERFLOW
);

  localparam int              DW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST    = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0]   PREFILL_LVL = LW'(FIFO_DEPTH / 2);
  localparam int              SW          = $clog2(SLOTS_PER_FRAME);
  localparam logic [SW-1:0]   RIGHT_SLOT  = SW'(SLOTS_PER_FRAME / 2);

  snd_state_t            state;
  logic [DW-1:0]         div;
  logic [SW-1:0]         slot;
  logic [2*SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0]   last_sample;

  logic                  fifo_pop;
  logic [7:0]            fifo_data;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  bclk_fall;
  logic                  frame_start;
  logic                  starve;
  logic                  drop;
  logic [SAMPLE_W-1:0]   frame_word;

  snd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (I_SND_VALID),
    .wr_data (I_SND),
    .pop     (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (O_LEVEL)
  );

  always_comb begin
    bclk_fall   = (state == RUN) && O_BCLK && (div == DIV_LAST);
    frame_start = bclk_fall && (slot == '0);
    fifo_pop    = frame_start && !fifo_empty;
    starve      = frame_start && fifo_empty;
    // A pop in the same cycle frees a slot, so only a push without a pop is lost.
    drop        = I_SND_VALID && fifo_full && !fifo_pop;
    frame_word  = fifo_empty ? last_sample
                             : apply_vol(u8_to_s16(fifo_data), I_VOL);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= PREFILL;
      div         <= '0;
      slot        <= '0;
      shreg       <= '0;
      last_sample <= '0;
      O_BCLK      <= 1'b0;
      O_LRCK      <= 1'b0;
      O_SDATA     <= 1'b0;
      O_UNDERRUN  <= 1'b0;
      O_OVERFLOW  <= 1'b0;
    end else begin
      if (starve)           O_UNDERRUN <= 1'b1;
      else if (I_CLR_FLAGS) O_UNDERRUN <= 1'b0;

      if (drop)             O_OVERFLOW <= 1'b1;
      else if (I_CLR_FLAGS) O_OVERFLOW <= 1'b0;

      case (state)
        PREFILL: begin
          div     <= '0;
          slot    <= '0;
          O_BCLK  <= 1'b0;
          O_LRCK  <= 1'b0;
          O_SDATA <= 1'b0;
          if (O_LEVEL >= PREFILL_LVL) state <= RUN;
        end
        RUN: begin
          if (div == DIV_LAST) begin
            div    <= '0;
            O_BCLK <= ~O_BCLK;
          end else begin
            div <= div + 1'b1;
          end
          // The shifter is loaded at slot 0 and shifted on slots 1..31, so
          // after 31 shifts its MSB holds the previous right bit 0 exactly
          // when slot 0 of the next frame needs it. A zeroed shifter gives
          // the silent slot 0 of the first frame.
          if (bclk_fall) begin
            O_SDATA <= shreg[2*SAMPLE_W-1];
            O_LRCK  <= (slot >= RIGHT_SLOT);
            slot    <= slot + 1'b1;
            if (slot == '0) begin
              shreg       <= {frame_word, frame_word};
              last_sample <= frame_word;
            end else begin
              shreg <= {shreg[2*SAMPLE_W-2:0], 1'b0};
            end
          end
        end
        default: state <= PREFILL;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_snd_i2s.sv
`timescale 1ns/1ps
module tb_wave_snd_i2s;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] I_SND   = 8'h00;
  logic       I_SND_VALID = 1'b0;
  logic [3:0] I_VOL   = 4'd15;
  logic       I_CLR_FLAGS = 1'b0;
  logic       O_BCLK, O_LRCK, O_SDATA, O_UNDERRUN, O_OVERFLOW;
  logic [4:0] O_LEVEL;

  int n_checks = 0;
  int n_pass   = 0;

  wave_snd_i2s #(.CLK_DIV(2), .FIFO_DEPTH(16)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .I_SND       (I_SND),
    .I_SND_VALID (I_SND_VALID),
    .I_VOL       (I_VOL),
    .I_CLR_FLAGS (I_CLR_FLAGS),
    .O_BCLK      (O_BCLK),
    .O_LRCK      (O_LRCK),
    .O_SDATA     (O_SDATA),
    .O_LEVEL     (O_LEVEL),
    .O_UNDERRUN  (O_UNDERRUN),
    .O_OVERFLOW  (O_OVERFLOW)
  );

  always #5 clk_sys = ~clk_sys;

  // Serial monitor: sampled on the falling clk_sys edge, away from updates.
  int          mon_slot = 0;
  int          ev_cnt   = 0;
  int          lr_err   = 0;
  logic        prev_bclk = 1'b0;
  logic        prev_lrck = 1'b0;
  logic        first_bit = 1'b1;
  logic        pop_next  = 1'b0;
  logic [15:0] cur_l = '0;
  logic [15:0] cur_r = '0;
  logic [15:0] cap_l [0:127];
  logic [15:0] cap_r [0:127];
  time         last_rise = 0;
  time         lr_period = 0;

  always @(negedge clk_sys) begin
    if (reset) begin
      mon_slot = 0; ev_cnt = 0; lr_err = 0; prev_bclk = 1'b0; prev_lrck = 1'b0;
      first_bit = 1'b1; pop_next = 1'b0; last_rise = 0; lr_period = 0;
    end else begin
      pop_next = O_BCLK && prev_bclk && (mon_slot == 0);
      if (prev_bclk && !O_BCLK) begin
        if (O_LRCK !== (mon_slot >= 16)) lr_err++;
        if (mon_slot == 0) begin
          if (ev_cnt == 0) first_bit = O_SDATA;
          else begin
            cur_r = {cur_r[14:0], O_SDATA};
            if (ev_cnt <= 128) begin
              cap_l[ev_cnt-1] = cur_l;
              cap_r[ev_cnt-1] = cur_r;
            end
          end
          ev_cnt++;
        end else if (mon_slot <= 16) cur_l = {cur_l[14:0], O_SDATA};
        else cur_r = {cur_r[14:0], O_SDATA};
        mon_slot = (mon_slot + 1) % 32;
      end
      if (!prev_lrck && O_LRCK) begin
        if (last_rise != 0) lr_period = $time - last_rise;
        last_rise = $time;
      end
      prev_bclk = O_BCLK;
      prev_lrck = O_LRCK;
    end
  end

  function automatic logic [15:0] model(input logic [7:0] u, input logic [3:0] v);
    int s;
    s = (int'(u) - 128) * 256 * (int'(v) + 1);
    s = s >>> 4;
    return s[15:0];
  endfunction

  task automatic do_reset();
    reset = 1'b1; I_SND_VALID = 1'b0; I_CLR_FLAGS = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic push_burst(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys); I_SND = v; I_SND_VALID = 1'b1;
    end
    @(negedge clk_sys); I_SND_VALID = 1'b0;
  endtask

  task automatic wait_ev(input int n, input int budget);
    for (int i = 0; i < budget && ev_cnt < n; i++) begin
      @(negedge clk_sys); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    n_checks++; if ({O_BCLK, O_LRCK, O_SDATA} !== 3'b000) $display("FAIL reset_pins: got %b want 000", {O_BCLK, O_LRCK, O_SDATA}); else n_pass++;
    n_checks++; if (O_LEVEL !== 5'd0) $display("FAIL reset_level: got %0d want 0", O_LEVEL); else n_pass++;
    n_checks++; if ({O_UNDERRUN, O_OVERFLOW} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {O_UNDERRUN, O_OVERFLOW}); else n_pass++;
  endtask

  task automatic test_prefill();
    do_reset();
    I_VOL = 4'd15;
    push_burst(8'hFF, 7);
    repeat (30) @(negedge clk_sys);
    n_checks++; if (O_LEVEL !== 5'd7) $display("FAIL prefill_level7: got %0d want 7", O_LEVEL); else n_pass++;
    n_checks++; if ({O_BCLK, O_LRCK} !== 2'b00) $display("FAIL prefill_idle: got %b want 00", {O_BCLK, O_LRCK}); else n_pass++;
    push_burst(8'hFF, 1);
    n_checks++; if (O_LEVEL !== 5'd8) $display("FAIL prefill_level8: got %0d want 8", O_LEVEL); else n_pass++;
    wait_ev(4, 1000);
    n_checks++; if (ev_cnt < 4) $display("FAIL prefill_frames: got %0d want 4", ev_cnt); else n_pass++;
    n_checks++; if (first_bit !== 1'b0) $display("FAIL first_slot0: got %b want 0", first_bit); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (cap_l[k] !== 16'h7F00) $display("FAIL ff_left[%0d]: got %h want 7f00", k, cap_l[k]); else n_pass++;
      n_checks++; if (cap_r[k] !== 16'h7F00) $display("FAIL ff_right[%0d]: got %h want 7f00", k, cap_r[k]); else n_pass++;
    end
    n_checks++; if (lr_period !== 1280) $display("FAIL lrck_period: got %0t want 1280", lr_period); else n_pass++;
    n_checks++; if (lr_err !== 0) $display("FAIL lrck_slots: got %0d errors want 0", lr_err); else n_pass++;
  endtask

  // Continues from test_prefill: eight entries drain, then frames starve.
  task automatic test_underrun();
    wait_ev(8, 1500);
    n_checks++; if ({O_UNDERRUN, O_LEVEL} !== 6'b0_00000) $display("FAIL drained: got uf=%b lvl=%0d want 0/0", O_UNDERRUN, O_LEVEL); else n_pass++;
    wait_ev(9, 300);
    n_checks++; if (O_UNDERRUN !== 1'b1) $display("FAIL underrun_set: got %b want 1", O_UNDERRUN); else n_pass++;
    wait_ev(10, 300);
    n_checks++; if ({cap_l[8], cap_r[8]} !== {16'h7F00, 16'h7F00}) $display("FAIL repeat_word: got %h/%h want 7f00/7f00", cap_l[8], cap_r[8]); else n_pass++;
    @(negedge clk_sys); I_CLR_FLAGS = 1'b1;
    @(negedge clk_sys); I_CLR_FLAGS = 1'b0;
    n_checks++; if (O_UNDERRUN !== 1'b0) $display("FAIL underrun_clear: got %b want 0", O_UNDERRUN); else n_pass++;
    wait_ev(11, 300);
    n_checks++; if (O_UNDERRUN !== 1'b1) $display("FAIL underrun_reset: got %b want 1", O_UNDERRUN); else n_pass++;
    // Clear during the starving frame start: the set must win.
    @(negedge clk_sys); I_CLR_FLAGS = 1'b1;
    @(negedge clk_sys); I_CLR_FLAGS = 1'b0;
    for (int i = 0; i < 300 && !pop_next; i++) begin @(negedge clk_sys); #1; end
    I_CLR_FLAGS = 1'b1;
    @(negedge clk_sys); I_CLR_FLAGS = 1'b0; #1;
    n_checks++; if (O_UNDERRUN !== 1'b1) $display("FAIL set_beats_clear: got %b want 1", O_UNDERRUN); else n_pass++;
  endtask

  task automatic test_convert();
    logic [7:0]  samp [8];
    logic [3:0]  vol  [8];
    logic [15:0] exp_w[8];
    samp = '{8'h00, 8'h00, 8'hFF, 8'h80, 8'h80, 8'hFF, 8'h00, 8'h80};
    vol  = '{4'd15, 4'd7, 4'd7, 4'd15, 4'd0, 4'd15, 4'd0, 4'd3};
    exp_w = '{16'h8000, 16'hC000, 16'h3F80, 16'h0000, 16'h0000, 16'h7F00, 16'hF800, 16'h0000};
    do_reset();
    I_VOL = vol[0];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys); I_SND = samp[i]; I_SND_VALID = 1'b1;
    end
    @(negedge clk_sys); I_SND_VALID = 1'b0;
    for (int k = 0; k < 7; k++) begin
      wait_ev(k + 1, 300);
      I_VOL = vol[k+1];
    end
    wait_ev(9, 600);
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (cap_l[k] !== exp_w[k]) $display("FAIL conv_left[%0d]: got %h want %h", k, cap_l[k], exp_w[k]); else n_pass++;
      n_checks++; if (cap_r[k] !== exp_w[k]) $display("FAIL conv_right[%0d]: got %h want %h", k, cap_r[k], exp_w[k]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int ev0;
    do_reset();
    push_burst(8'h80, 20);
    n_checks++; if (O_LEVEL !== 5'd16) $display("FAIL burst_level: got %0d want 16", O_LEVEL); else n_pass++;
    n_checks++; if (O_OVERFLOW !== 1'b1) $display("FAIL overflow_set: got %b want 1", O_OVERFLOW); else n_pass++;
    @(negedge clk_sys); I_CLR_FLAGS = 1'b1;
    @(negedge clk_sys); I_CLR_FLAGS = 1'b0;
    n_checks++; if (O_OVERFLOW !== 1'b0) $display("FAIL overflow_clear: got %b want 0", O_OVERFLOW); else n_pass++;
    for (int i = 0; i < 300 && !pop_next; i++) begin @(negedge clk_sys); #1; end
    ev0 = ev_cnt;
    I_SND = 8'h11; I_SND_VALID = 1'b1;
    @(negedge clk_sys); I_SND_VALID = 1'b0; #1;
    n_checks++; if (ev_cnt !== ev0 + 1) $display("FAIL pushpop_aligned: got %0d want %0d", ev_cnt, ev0 + 1); else n_pass++;
    n_checks++; if (O_LEVEL !== 5'd16) $display("FAIL pushpop_level: got %0d want 16", O_LEVEL); else n_pass++;
    n_checks++; if (O_OVERFLOW !== 1'b0) $display("FAIL pushpop_no_ovf: got %b want 0", O_OVERFLOW); else n_pass++;
  endtask

  task automatic test_midframe_reset();
    logic found;
    logic seen;
    found = 1'b0;
    seen  = 1'b0;
    do_reset();
    I_VOL = 4'd15;
    push_burst(8'hFF, 8);
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk_sys); #1;
      if (ev_cnt >= 1 && mon_slot == 11 && O_BCLK) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) $display("FAIL reach_slot10: got %b want 1", found); else n_pass++;
    reset = 1'b1; #1;
    n_checks++; if ({O_BCLK, O_LRCK, O_SDATA} !== 3'b000) $display("FAIL async_pins: got %b want 000", {O_BCLK, O_LRCK, O_SDATA}); else n_pass++;
    n_checks++; if (O_LEVEL !== 5'd0) $display("FAIL async_level: got %0d want 0", O_LEVEL); else n_pass++;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys);
      if (O_BCLK !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL idle_after_reset: got %b want 0", seen); else n_pass++;
    push_burst(8'hFF, 8);
    wait_ev(1, 100);
    n_checks++; if (ev_cnt < 1) $display("FAIL restart: got %0d want 1", ev_cnt); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] samp [64];
    logic [3:0] vol  [64];
    for (int i = 0; i < 64; i++) begin
      samp[i] = 8'($urandom_range(255, 0));
      vol[i]  = 4'($urandom_range(15, 0));
    end
    do_reset();
    I_VOL = vol[0];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys); I_SND = samp[i]; I_SND_VALID = 1'b1;
    end
    @(negedge clk_sys); I_SND_VALID = 1'b0;
    for (int k = 0; k < 64; k++) begin
      wait_ev(k + 1, 300);
      if (k < 63) I_VOL = vol[k+1];
      if (k + 8 < 64) push_burst(samp[k+8], 1);
    end
    n_checks++; if (O_UNDERRUN !== 1'b0) $display("FAIL random_no_starve: got %b want 0", O_UNDERRUN); else n_pass++;
    wait_ev(65, 300);
    for (int k = 0; k < 64; k++) begin
      n_checks++; if (cap_l[k] !== model(samp[k], vol[k])) $display("FAIL rand_left[%0d]: got %h want %h", k, cap_l[k], model(samp[k], vol[k])); else n_pass++;
      n_checks++; if (cap_r[k] !== model(samp[k], vol[k])) $display("FAIL rand_right[%0d]: got %h want %h", k, cap_r[k], model(samp[k], vol[k])); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_underrun();
    test_convert();
    test_back_to_back();
    test_midframe_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wave_snd_i2s.md
Name: wave_snd_i2s

Overview:
- Downstream audio output stage for wave_sound.
- Accepts 8-bit unsigned wave samples strobed from O_SND and buffers them in a small FIFO.
- Converts samples to signed 16-bit, applies a 4-bit volume, and serialises them as mono-duplicated stereo I2S.
- Sits between wave_sound and the board/sim audio pins; all logic runs in the clk_sys domain.

Parameters:
- CLK_DIV, 2: clk_sys cycles per BCLK half-period (≥1). Frame = 32 slots, so 64*CLK_DIV clk_sys cycles per frame.
- FIFO_DEPTH, 16: sample FIFO entries, power of two, ≥4.
- LW, $clog2(FIFO_DEPTH)+1: derived level width, not overridable.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- I_SND, in, 8: unsigned sample; 0x80 is zero level.
- I_SND_VALID, in, 1: one-cycle push strobe.
- I_VOL, in, 4: volume; gain = (I_VOL+1)/16, so 15 is unity.
- I_CLR_FLAGS, in, 1: clears the sticky flags.
- O_BCLK, out, 1: I2S bit clock.
- O_LRCK, out, 1: word select; 0 = left.
- O_SDATA, out, 1: serial data, MSB first.
- O_LEVEL, out, LW: FIFO occupancy.
- O_UNDERRUN, out, 1: sticky; set when a pop is attempted on an empty FIFO.
- O_OVERFLOW, out, 1: sticky; set when a push is dropped on a full FIFO.

Behaviour:
- Reset (async): O_BCLK=0, O_LRCK=0, O_SDATA=0, O_LEVEL=0, both flags=0. FIFO is emptied, last_sample=0x0000, state=PREFILL, divider=0, slot=0.
- Conversion, combinational on pop:
  - s16 = {I_SND[7]^1, I_SND[6:0], 8'h00}.
  - 21-bit signed product p = s16 * {1'b0, I_VOL+1}.
  - out16 = p >>> 4 (arithmetic shift), truncated to 16 bits. No saturation is needed.
  - Volume is sampled at pop time, not at push time.
- FIFO:
  - Push on I_SND_VALID when not full. A push when full is dropped and sets O_OVERFLOW.
  - Simultaneous push and pop while full: the pop frees a slot, the push is accepted, no overflow.
  - O_LEVEL updates the cycle after the push or pop.
- State PREFILL: BCLK held 0, LRCK 0, SDATA 0, divider idle. Go to RUN on the cycle that O_LEVEL ≥ FIFO_DEPTH/2.
- State RUN:
  - The divider counts 0..CLK_DIV-1 and toggles O_BCLK at wrap.
  - Slot counter 0..31 advances and O_SDATA/O_LRCK update on each BCLK falling edge (1→0 toggle). The first falling edge after entering RUN is slot 0.
  - At slot 0: pop one FIFO entry, convert it, and load {L=out16, R=out16} into a 32-bit shift register.
  - If the FIFO is empty at slot 0: reuse last_sample and set O_UNDERRUN. RUN continues; there is no return to PREFILL.
- Slot map (standard I2S, one-BCLK delay):
  - Slot 0: SDATA = previous frame right bit0.
  - Slots 1..16: left bits 15..0.
  - Slots 17..31: right bits 15..1.
  - O_LRCK = 0 for slots 0..15, 1 for slots 16..31.
- The first frame after PREFILL outputs 0 at slot 0.
- I_CLR_FLAGS clears both flags next cycle. If the clear coincides with a setting event, the set wins.
- Reset mid-frame: all outputs return to reset values immediately. The FIFO contents are discarded.

Decomposition:
- Package wave_snd_pkg:
  - SLOTS_PER_FRAME=32, SAMPLE_W=16.
  - state enum {PREFILL, RUN}.
  - function u8_to_s16.
- Sub-module snd_fifo: synchronous single-clock FIFO, parameterised by depth and width, providing full/empty/level. The top level holds the divider, slot counter, shifter, volume multiply and flags.

Test Plan:
- Reset, then push 8 samples of 0xFF with I_VOL=15, CLK_DIV=2 → PREFILL exits when level hits 8. First frame: slot 0 is 0 and carries the loaded word. Frames carry 0x7F00 on L and R. LRCK period is 128 clk_sys.
- Push 0x00 with I_VOL=15 → word 0x8000. Push 0x00 with I_VOL=7 → 0xC000. Push 0xFF with I_VOL=7 → 0x3F80. Push 0x80 → 0x0000 at any volume.
- Prefill to 8, then stop pushing → after 8 frames the next slot-0 sets O_UNDERRUN. The last word repeats. I_CLR_FLAGS clears the flag, and it re-sets at the next frame.
- 20 back-to-back pushes from empty → 16 accepted, O_OVERFLOW=1, O_LEVEL=16. Push and pop in the same cycle at full → level stays 16, no new overflow after a clear.
- Assert reset at slot 10 of a frame → BCLK/LRCK/SDATA=0 and O_LEVEL=0 immediately. PREFILL is re-entered; no serial activity until 8 new pushes.
- Check the bit-order golden model over 64 random samples with random I_VOL → captured L and R words equal the expected conversion, both channels identical.
